pingpong_buf_ctrl: RTL and testbench
====================================

// Module: pingpong_buf_ctrl
// PURPOSE
//  Single-port sequencer that runs the 2-entry x DW-bit block RAM (CLK, EN, WE[3:0], A[12:0], Di, Do) as an in-order 2-slot buffer.
//  Sits between a valid/ready write stream and a valid/ready read stream.
//  Arbitrates the one RAM port between the two streams, hides the 1-cycle registered-address read latency, and adds one output register.
//  Total capacity: 3 words (2 RAM slots + output register).
// PARAMETERS
//  DW  128  data width; equals RAM word width
//  AW  13   RAM byte-address width
//  WL  2    RAM slots; design fixed at 2 (1-bit pointers), elaboration error otherwise
// PORTS
//  CLK        in   1    clock, all logic on posedge
//  RST        in   1    synchronous reset, active-high
//  flush      in   1    synchronous clear of buffer contents (not config)
//  wr_valid   in   1    write word offered
//  wr_ready   out  1    write word accepted this cycle when wr_valid=1
//  wr_data    in   DW   write word
//  rd_valid   out  1    rd_data holds a word
//  rd_ready   in   1    consumer takes rd_data this cycle
//  rd_data    out  DW   output register
//  level      out  2    words held in RAM slots (0..2), excludes output register
//  ram_en     out  1    to RAM EN
//  ram_we     out  4    to RAM WE: 4'hF for a write, 4'h0 otherwise
//  ram_a      out  AW   to RAM A: slot k -> k<<2 (RAM indexes A>>2)
//  ram_di     out  DW   to RAM Di; wired to wr_data
//  ram_do     in   DW   from RAM Do; valid only while EN=1, for the address of the previous cycle
// BEHAVIOUR
//  Reset (RST=1, next edge): wptr=rptr=0, level=0, rd_pending=0, rd_valid=0, rd_data=0, prio=WR.
//   While RST=1: wr_ready=0, ram_en=0, ram_we=0, ram_a=0.
//  Eligibility:
//   wr_ok   = level<2 && !flush
//   rd_elig = level>0 && !rd_pending && !flush && (!rd_valid || rd_ready)
//  Arbitration (one RAM access per cycle):
//   conflict = wr_valid && wr_ok && rd_elig; the winner is prio, then prio flips to the other side
//   wr_ready = wr_ok && (!rd_elig || prio==WR); depends on no wr_valid (no comb loop)
//   rd_go    = rd_elig && !(wr_valid && wr_ready)
//   Idle requester never blocks the other
//  Write grant (wr_valid&&wr_ready): ram_en=1, ram_we=F, ram_a=wptr<<2; wptr^=1; level+1
//  Read issue (rd_go): ram_en=1, ram_we=0, ram_a=rptr<<2; rptr^=1; level-1; rd_pending<=1
//   A same-cycle write grant and read issue cannot happen, so level never changes by +1-1
//  Capture (rd_pending=1): ram_en forced 1 (RAM Do gated by EN); rd_data<=ram_do; rd_valid<=1; rd_pending<=0
//   A write may be granted in the capture cycle; its address does not disturb the captured data
//  Output: rd_valid&&rd_ready clears rd_valid unless a capture loads a new word that cycle
//   rd_data holds its value while rd_valid=1 && rd_ready=0
//  Idle (no grant, no capture): ram_en=0, ram_we=0, ram_a keeps last value
//  Latency: write granted in cycle N into an empty buffer, rd_ready=1 -> read issue N+1, capture N+2, rd_valid=1 in N+3
//  Read-after-write to the same slot in consecutive cycles returns the new data
//  Order: strict FIFO; pointers wrap 1->0; slot addresses alternate 0,4,0,4
//  Full: level=2 -> wr_ready=0. Empty: level=0 -> no read issue; rd_valid falls after the last pop
//  flush (priority below RST, above all else): the next edge clears pointers, level, rd_pending, rd_valid
//   An in-flight capture is dropped; wr_ready=0 and no RAM access during the flush cycle
//  RST mid-transfer: identical to flush plus prio=WR; RAM contents are not cleared (not needed)
// TESTING
//  1 RST=1 for 3 cycles with wr_valid=1 -> wr_ready=0, ram_en=0, rd_valid=0, level=0 throughout
//  2 Empty, rd_ready=1, write 128'hA5A5..A5 at cycle N
//    -> N: ram_a=0, ram_we=F; N+1: ram_a=0, ram_we=0; N+3: rd_valid=1, rd_data=128'hA5A5..A5
//  3 rd_ready=0, wr_valid=1 continuously with words 1,2,3,4
//    -> exactly 3 accepted (slots 0,4,0); then wr_ready=0, level=2, rd_valid=1, rd_data=1 held stable
//  4 level=1, rd_valid=0, wr_valid=1, prio=WR
//    -> write granted, prio=RD; next cycle with both eligible, the read is granted and wr_ready=0
//  5 Stream 8 words 1..8 with rd_ready toggling 1,0,0,1,...
//    -> output order 1..8; ram_a alternates 0,4; level never exceeds 2; no accepted word lost
//  6 flush asserted in the capture cycle of a read
//    -> the next cycle has rd_valid=0 and level=0, and the next write goes to ram_a=0

Source files
------------

// File: rtl/pingpong_buf_ctrl_if.sv
// Interface: pingpong_buf_ctrl_if
// Purpose: bundles the write stream, read stream and single-port RAM bus
//          seen by pingpong_buf_ctrl.
// Signals:
//   wr_valid/wr_ready/wr_data   write stream (producer -> buffer)
//   rd_valid/rd_ready/rd_data   read stream (buffer -> consumer)
//   ram_en/ram_we/ram_a/ram_di  controller -> RAM port
//   ram_do                      RAM -> controller read data
// Modports: slave = controller view, master = environment view.
interface pingpong_buf_ctrl_if #(
  parameter int DW = 128,
  parameter int AW = 13
);
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  modport slave (
    input  wr_valid, wr_data, rd_ready, ram_do,
    output wr_ready, rd_valid, rd_data, ram_en, ram_we, ram_a, ram_di
  );

  modport master (
    output wr_valid, wr_data, rd_ready, ram_do,
    input  wr_ready, rd_valid, rd_data, ram_en, ram_we, ram_a, ram_di
  );
endinterface

// File: rtl/pingpong_buf_ctrl.sv
// Module: pingpong_buf_ctrl
// Purpose: runs a 2-entry single-port block RAM as an in-order 2-slot buffer
//          between a valid/ready write stream and a valid/ready read stream,
//          arbitrating the one RAM port, hiding the registered-address read
//          latency and adding one output register (3 words total).
// Ports:
//   CLK    in   clock, all logic on posedge
//   RST    in   synchronous active-high reset
//   flush  in   synchronous clear of buffer contents
//   level  out  words held in the RAM slots (0..2), output register excluded
//   bus    slave modport of pingpong_buf_ctrl_if (streams + RAM port)
module pingpong_buf_ctrl #(
  parameter int DW = 128,
  parameter int AW = 13,
  parameter int WL = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                flush,
  output logic [1:0]          level,
  pingpong_buf_ctrl_if.slave  bus
);

  // Pointers are a single bit each, so only a 2-slot RAM is supported.
  if (WL != 2) begin : g_wl_check
    $error("pingpong_buf_ctrl: WL must be 2");
  end

  // Which side wins the next write/read conflict on the RAM port.
  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_t;

  prio_t         prio_q, prio_d;
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [1:0]    level_q, level_d;
  logic          rd_pending_q, rd_pending_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [AW-1:0] ram_a_q, ram_a_d;

  logic wr_ok;
  logic rd_elig;
  logic wr_ready_c;
  logic wr_go;
  logic rd_go;
  logic capture;
  logic conflict;

  // RAM indexes A>>2, so slot k lives at byte address k<<2.
  function automatic logic [AW-1:0] slot_addr(input logic p);
    logic [AW-1:0] a;
    a    = '0;
    a[2] = p;
    return a;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_q       <= PRIO_WR;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      level_q      <= 2'd0;
      rd_pending_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      ram_a_q      <= '0;
    end else begin
      prio_q       <= prio_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      level_q      <= level_d;
      rd_pending_q <= rd_pending_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      ram_a_q      <= ram_a_d;
    end
  end

  always_comb begin
    wr_ok    = (level_q < 2'd2) && !flush;
    rd_elig  = (level_q != 2'd0) && !rd_pending_q && !flush &&
               (!rd_valid_q || bus.rd_ready);
    // wr_ready never looks at wr_valid, so no combinational loop through
    // an upstream that waits for ready before raising valid.
    wr_ready_c = !RST && wr_ok && (!rd_elig || prio_q == PRIO_WR);
    wr_go    = bus.wr_valid && wr_ready_c;
    rd_go    = !RST && rd_elig && !wr_go;
    // RAM Do is gated by EN, so the capture cycle must keep EN high.
    capture  = !RST && !flush && rd_pending_q;
    conflict = bus.wr_valid && wr_ok && rd_elig;

    prio_d       = prio_q;
    wptr_d       = wptr_q ^ wr_go;
    rptr_d       = rptr_q ^ rd_go;
    level_d      = level_q;
    rd_pending_d = rd_go;
    rd_valid_d   = rd_valid_q;
    rd_data_d    = rd_data_q;
    ram_a_d      = ram_a_q;

    if (conflict) begin
      prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
    end

    // Write grant and read issue are mutually exclusive.
    if (wr_go) begin
      level_d = level_q + 2'd1;
      ram_a_d = slot_addr(wptr_q);
    end else if (rd_go) begin
      level_d = level_q - 2'd1;
      ram_a_d = slot_addr(rptr_q);
    end

    if (capture) begin
      rd_valid_d = 1'b1;
      rd_data_d  = bus.ram_do;
    end else if (rd_valid_q && bus.rd_ready) begin
      rd_valid_d = 1'b0;
    end

    // An in-flight capture is dropped; rd_data itself is left alone.
    if (flush) begin
      wptr_d       = 1'b0;
      rptr_d       = 1'b0;
      level_d      = 2'd0;
      rd_pending_d = 1'b0;
      rd_valid_d   = 1'b0;
    end

    bus.wr_ready = wr_ready_c;
    bus.ram_en   = wr_go || rd_go || capture;
    bus.ram_we   = wr_go ? 4'hF : 4'h0;
    bus.ram_a    = RST ? '0 : ram_a_d;
  end

  assign bus.ram_di   = bus.wr_data;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign level        = level_q;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Testbench: tb_pingpong_buf_ctrl
// Purpose: table-driven cycle vectors for reset, latency, full and
//          arbitration behaviour, plus hand-written streaming and flush
//          sequences. A queue scoreboard follows every accepted write and
//          checks each word popped from the read side.
module tb_pingpong_buf_ctrl;
  localparam int DW = 128;
  localparam int AW = 13;

  logic       CLK;
  logic       RST;
  logic       flush;
  logic [1:0] level;

  pingpong_buf_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  pingpong_buf_ctrl #(.DW(DW), .AW(AW), .WL(2)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .flush (flush),
    .level (level),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural 2-entry RAM with registered address, Do gated by EN.
  logic [DW-1:0] mem [0:1];
  logic [AW-1:0] addr_q;

  initial begin
    mem[0] = '0;
    mem[1] = '0;
    addr_q = '0;
  end

  always @(posedge CLK) begin
    if (bus.ram_en) begin
      if (bus.ram_we == 4'hF) mem[bus.ram_a[2]] <= bus.ram_di;
      addr_q <= bus.ram_a;
    end
  end

  assign bus.ram_do = bus.ram_en ? mem[addr_q[2]] : '0;

  int check_count = 0;
  int pass_count  = 0;
  int pop_count   = 0;
  logic [DW-1:0] sb_q [$];

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the edge, return at the negedge
  // so the caller samples settled outputs for that cycle.
  task automatic applyStimulus(input logic r, input logic f, input logic wv,
                               input logic [DW-1:0] wd, input logic rr);
    @(posedge CLK);
    #1;
    RST          = r;
    flush        = f;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    @(negedge CLK);
  endtask

  function automatic logic [DW-1:0] word(input int b);
    logic [7:0] bb;
    bb = b[7:0];
    return {(DW/8){bb}};
  endfunction

  // Scoreboard: push on write acceptance, pop and compare on read handshake.
  always @(negedge CLK) begin
    if (RST || flush) begin
      sb_q.delete();
    end else begin
      if (bus.rd_valid && bus.rd_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_pop_with_empty_queue", DW'(1), DW'(0));
        end else begin
          checkOutput("sb_rd_data", bus.rd_data, sb_q.pop_front());
        end
        pop_count++;
      end
      if (bus.wr_valid && bus.wr_ready) sb_q.push_back(bus.wr_data);
    end
  end

  typedef struct {
    logic          rst;
    logic          flush;
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic          e_wr_ready;
    logic          e_rd_valid;
    logic [1:0]    e_level;
    logic          e_ram_en;
    logic [3:0]    e_ram_we;
    logic [AW-1:0] e_ram_a;
    logic          chk_data;
    logic [DW-1:0] e_rd_data;
  } vec_t;

  function automatic vec_t mk(int rst, int fl, int wv, int wdb, int rr,
                              int ewr, int erv, int elev, int een, int ewe,
                              int ea, int chk, int edb);
    vec_t v;
    v.rst        = rst[0];
    v.flush      = fl[0];
    v.wv         = wv[0];
    v.wd         = word(wdb);
    v.rr         = rr[0];
    v.e_wr_ready = ewr[0];
    v.e_rd_valid = erv[0];
    v.e_level    = elev[1:0];
    v.e_ram_en   = een[0];
    v.e_ram_we   = ewe[3:0];
    v.e_ram_a    = AW'(ea);
    v.chk_data   = chk[0];
    v.e_rd_data  = word(edb);
    return v;
  endfunction

  localparam int NV = 25;
  vec_t vecs [NV];

  initial begin
    int next_word;
    int base;
    logic [AW-1:0] exp_slot;

    RST          = 1'b1;
    flush        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;

    //            rst fl wv wd   rr | wrr rv lev en we   a  chk data
    vecs[0]  = mk(1, 0, 1, 'hAA, 0,   0,  0, 0,  0, 0,   0, 0, 0);
    vecs[1]  = mk(1, 0, 1, 'hAA, 0,   0,  0, 0,  0, 0,   0, 0, 0);
    vecs[2]  = mk(1, 0, 1, 'hAA, 0,   0,  0, 0,  0, 0,   0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 'hA5, 1,   1,  0, 0,  1, 'hF, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0,    1,   1,  0, 1,  1, 0,   0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0,    1,   1,  0, 0,  1, 0,   0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0,    0,   1,  1, 0,  0, 0,   0, 1, 'hA5);
    vecs[7]  = mk(1, 0, 0, 0,    0,   0,  1, 0,  0, 0,   0, 1, 'hA5);
    vecs[8]  = mk(0, 0, 1, 1,    0,   1,  0, 0,  1, 'hF, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 2,    0,   1,  0, 1,  1, 'hF, 4, 0, 0);
    vecs[10] = mk(0, 0, 1, 3,    0,   0,  0, 2,  1, 0,   0, 0, 0);
    vecs[11] = mk(0, 0, 1, 3,    0,   1,  0, 1,  1, 'hF, 0, 0, 0);
    vecs[12] = mk(0, 0, 1, 4,    0,   0,  1, 2,  0, 0,   0, 1, 1);
    vecs[13] = mk(0, 0, 1, 4,    0,   0,  1, 2,  0, 0,   0, 1, 1);
    vecs[14] = mk(0, 0, 0, 0,    1,   0,  1, 2,  1, 0,   4, 1, 1);
    vecs[15] = mk(0, 0, 0, 0,    1,   1,  0, 1,  1, 0,   4, 0, 0);
    vecs[16] = mk(0, 0, 1, 5,    1,   0,  1, 1,  1, 0,   0, 1, 2);
    vecs[17] = mk(0, 0, 1, 5,    1,   1,  0, 0,  1, 'hF, 4, 0, 0);
    vecs[18] = mk(0, 0, 1, 6,    1,   1,  1, 1,  1, 'hF, 0, 1, 3);
    vecs[19] = mk(0, 0, 1, 7,    1,   0,  0, 2,  1, 0,   4, 0, 0);
    vecs[20] = mk(0, 0, 0, 0,    1,   1,  0, 1,  1, 0,   4, 0, 0);
    vecs[21] = mk(0, 0, 0, 0,    1,   0,  1, 1,  1, 0,   0, 1, 5);
    vecs[22] = mk(0, 0, 0, 0,    1,   1,  0, 0,  1, 0,   0, 0, 0);
    vecs[23] = mk(0, 0, 0, 0,    1,   1,  1, 0,  0, 0,   0, 1, 6);
    vecs[24] = mk(0, 0, 0, 0,    0,   1,  0, 0,  0, 0,   0, 0, 0);

    $display("[TB] table vectors");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].wv, vecs[i].wd, vecs[i].rr);
      checkOutput($sformatf("v%0d_wr_ready", i), DW'(bus.wr_ready), DW'(vecs[i].e_wr_ready));
      checkOutput($sformatf("v%0d_rd_valid", i), DW'(bus.rd_valid), DW'(vecs[i].e_rd_valid));
      checkOutput($sformatf("v%0d_level", i), DW'(level), DW'(vecs[i].e_level));
      checkOutput($sformatf("v%0d_ram_en", i), DW'(bus.ram_en), DW'(vecs[i].e_ram_en));
      checkOutput($sformatf("v%0d_ram_we", i), DW'(bus.ram_we), DW'(vecs[i].e_ram_we));
      checkOutput($sformatf("v%0d_ram_a", i), DW'(bus.ram_a), DW'(vecs[i].e_ram_a));
      if (vecs[i].chk_data) begin
        checkOutput($sformatf("v%0d_rd_data", i), bus.rd_data, vecs[i].e_rd_data);
      end
    end

    $display("[TB] streaming 8 words with rd_ready pattern 1,0,0");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    next_word = 1;
    exp_slot  = '0;
    base      = pop_count;
    for (int cyc = 0; cyc < 300 && (pop_count - base) < 8; cyc++) begin
      applyStimulus(1'b0, 1'b0, next_word <= 8, word(next_word), (cyc % 3) == 0);
      if (bus.wr_valid && bus.wr_ready) begin
        checkOutput($sformatf("s5_ram_a_w%0d", next_word), DW'(bus.ram_a), DW'(exp_slot));
        exp_slot[2] = ~exp_slot[2];
        next_word++;
      end
      checkOutput($sformatf("s5_level_le2_c%0d", cyc), DW'(level <= 2'd2), DW'(1));
    end
    #1;
    checkOutput("s5_words_popped", DW'(pop_count - base), DW'(8));
    checkOutput("s5_words_accepted", DW'(next_word), DW'(9));

    $display("[TB] flush in capture cycle");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, word('h11), 1'b0);
    checkOutput("s6_wr_ram_a", DW'(bus.ram_a), DW'(0));
    checkOutput("s6_wr_ram_we", DW'(bus.ram_we), DW'(4'hF));
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("s6_rd_issue_en", DW'(bus.ram_en), DW'(1));
    checkOutput("s6_rd_issue_we", DW'(bus.ram_we), DW'(0));
    applyStimulus(1'b0, 1'b1, 1'b1, word('h22), 1'b1);
    checkOutput("s6_flush_wr_ready", DW'(bus.wr_ready), DW'(0));
    checkOutput("s6_flush_ram_en", DW'(bus.ram_en), DW'(0));
    applyStimulus(1'b0, 1'b0, 1'b1, word('h22), 1'b1);
    checkOutput("s6_after_rd_valid", DW'(bus.rd_valid), DW'(0));
    checkOutput("s6_after_level", DW'(level), DW'(0));
    checkOutput("s6_after_wr_ready", DW'(bus.wr_ready), DW'(1));
    checkOutput("s6_after_ram_a", DW'(bus.ram_a), DW'(0));
    checkOutput("s6_after_ram_we", DW'(bus.ram_we), DW'(4'hF));
    base = pop_count;
    for (int k = 0; k < 10 && pop_count == base; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    #1;
    checkOutput("s6_pop_after_flush", DW'(pop_count - base), DW'(1));
    checkOutput("sb_drained", DW'(sb_q.size()), DW'(0));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
